// File: rtl/aes_sched_pkg.sv
// Shared types for the AES core scheduler: core port structs, function encodings, FSM states.
// No logic; widths fixed to AES-256 keys and 128-bit blocks.
// Backpressure: n/a.
package aes_sched_pkg;

    localparam int AES_KEY_W  = 256;
    localparam int AES_DATA_W = 128;

    localparam logic [1:0] AES_FUNC_NONE = 2'd0;
    localparam logic [1:0] AES_FUNC_KEXP = 2'd1;
    localparam logic [1:0] AES_FUNC_ENC  = 2'd2;
    localparam logic [1:0] AES_FUNC_DEC  = 2'd3;

    typedef struct packed {
        logic                  enable;
        logic [1:0]            func;
        logic [AES_KEY_W-1:0]  key;
        logic [AES_DATA_W-1:0] data;
    } aes_in_type;

    typedef struct packed {
        logic [AES_DATA_W-1:0] result;
        logic                  ready;
    } aes_out_type;

    typedef enum logic [2:0] {
        IDLE,
        KEXP,
        KWAIT,
        START,
        WAIT,
        RESP
    } sched_state_type;

endpackage

// File: rtl/aes_sched_rr_arb.sv
// Round-robin picker: first asserted request at or after ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module aes_rr_arb
    import aes_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NREQ);
            if (req[cand]) begin
                grant = cand;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_sched.sv
// Round-robin share of one AES core; key re-expanded only on key change. Watchdog under AES_SCHED_TMO_EN.
// Latency: accept->rsp_valid = 3 + core cycles (key reuse), + 1 + KEXP_CYC on key change.
// Backpressure: response held until rsp_ready; no new grant while a transaction is in flight.
module aes_sched
    import aes_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int KEY_W    = AES_KEY_W,
    parameter int DATA_W   = AES_DATA_W,
    parameter int KEXP_CYC = 2,
    parameter int TMO_CYC  = 64
) (
    input  logic                    rst,
    input  logic                    clk,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_dec,
    input  logic [NREQ*KEY_W-1:0]   req_key,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_idx,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output aes_in_type              core_in,
    input  aes_out_type             core_out,
    output logic                    busy
);

    localparam int IDX_W   = $clog2(NREQ);
    localparam int CNT_MAX = (TMO_CYC > KEXP_CYC) ? TMO_CYC : KEXP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_type  state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, arb_grant, lat_idx;
    logic             arb_any, key_vld, lat_dec, key_miss, tmo_hit, cnt_run;
    logic [KEY_W-1:0] key_reg, lat_key, arb_key;
    logic [DATA_W-1:0] lat_data;
    logic [CNT_W-1:0] cnt;

    aes_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .any   (arb_any)
    );

    assign arb_key  = req_key[int'(arb_grant)*KEY_W +: KEY_W];
    assign key_miss = !key_vld || (arb_key != key_reg);

`ifdef AES_SCHED_TMO_EN
    logic err_q;
    assign tmo_hit = (state == WAIT) && !core_out.ready && (cnt == CNT_W'(TMO_CYC - 1));
    assign rsp_err = err_q;
    assign cnt_run = (state == KWAIT) || (state == WAIT);
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
    assign cnt_run = (state == KWAIT);
`endif

    assign rsp_valid = (state == RESP);
    assign rsp_idx   = lat_idx;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        core_in      = '0;
        core_in.key  = key_reg;
        core_in.data = lat_data;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    req_ready[arb_grant] = 1'b1;
                    state_nxt = key_miss ? KEXP : START;
                end
            end
            KEXP: begin
                // key_reg is only loaded at the end of this cycle, so the core sees the new key directly.
                core_in.enable = 1'b1;
                core_in.func   = AES_FUNC_KEXP;
                core_in.key    = lat_key;
                state_nxt      = KWAIT;
            end
            KWAIT: begin
                if (cnt == CNT_W'(KEXP_CYC - 1)) state_nxt = START;
            end
            START: begin
                core_in.enable = 1'b1;
                core_in.func   = lat_dec ? AES_FUNC_DEC : AES_FUNC_ENC;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (core_out.ready || tmo_hit) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            key_vld  <= 1'b0;
            key_reg  <= '0;
            lat_idx  <= '0;
            lat_dec  <= 1'b0;
            lat_key  <= '0;
            lat_data <= '0;
            cnt      <= '0;
            rsp_data <= '0;
`ifdef AES_SCHED_TMO_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        lat_idx  <= arb_grant;
                        lat_dec  <= req_dec[arb_grant];
                        lat_key  <= arb_key;
                        lat_data <= req_data[int'(arb_grant)*DATA_W +: DATA_W];
                        rr_ptr   <= (arb_grant == IDX_W'(NREQ - 1)) ? '0 : arb_grant + IDX_W'(1);
                    end
                end
                KEXP: begin
                    key_reg <= lat_key;
                    key_vld <= 1'b1;
                end
                WAIT: begin
                    if (core_out.ready) begin
                        rsp_data <= core_out.result;
`ifdef AES_SCHED_TMO_EN
                        err_q    <= 1'b0;
                    end else if (tmo_hit) begin
                        // Core state is unknown after a hang; force a fresh key expansion next time.
                        rsp_data <= '0;
                        err_q    <= 1'b1;
                        key_vld  <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sched.sv
// Self-checking bench for aes_sched: behavioural core model, round-robin reference and response scoreboard.
module tb_aes_sched;
    import aes_sched_pkg::*;

    localparam int NREQ     = 2;
    localparam int KEY_W    = 256;
    localparam int DATA_W   = 128;
    localparam int KEXP_CYC = 2;
    localparam int TMO_CYC  = 64;
    localparam int IDX_W    = $clog2(NREQ);

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [255:0] key;
        logic [127:0] data;
        logic         dec;
    } req_t;

    typedef struct {
        int           idx;
        logic [127:0] data;
        logic         err;
        int           kexp;
    } exp_t;

    logic                   rst, clk;
    logic [NREQ-1:0]        req_valid, req_ready, req_dec;
    logic [NREQ*KEY_W-1:0]  req_key;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   rsp_valid, rsp_ready, rsp_err, busy;
    logic [IDX_W-1:0]       rsp_idx;
    logic [DATA_W-1:0]      rsp_data;
    aes_in_type             core_in;
    aes_out_type            core_out;

    aes_sched #(.NREQ(NREQ), .KEY_W(KEY_W), .DATA_W(DATA_W), .KEXP_CYC(KEXP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .rst       (rst),
        .clk       (clk),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dec   (req_dec),
        .req_key   (req_key),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_idx   (rsp_idx),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .core_in   (core_in),
        .core_out  (core_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_chk, n_fail, cyc, done_cnt, kexp_cnt, start_cnt, kexp_base, start_base;
    int           kexp_cyc, start_cyc, core_lat, mptr, rdy_mode;
    logic         mvld, core_pend, core_stuck, tmo_mode, kexp_recent, prev_vld, prev_rdy;
    logic [255:0] mkey, exp_key;
    logic [127:0] core_res, prev_data;
    logic [IDX_W-1:0] prev_idx;
    logic [NREQ-1:0]  acc;
    int           gseq[$];
    exp_t         expq[$];
    req_t         rq[NREQ][$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in for the cipher: the real FIPS-197 pair, otherwise an invertible-looking mix.
    function automatic logic [127:0] ref_core(input logic [255:0] k, input logic [127:0] d, input logic dec);
        logic [127:0] salt;
        if (k == FIPS_KEY && !dec && d == FIPS_PT) return FIPS_CT;
        if (k == FIPS_KEY && dec && d == FIPS_CT) return FIPS_PT;
        salt = dec ? {4{32'h5a5a_5a5a}} : 128'd0;
        return d ^ k[127:0] ^ k[255:128] ^ salt;
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic push(input int i, input logic [255:0] k, input logic [127:0] d, input logic dec);
        req_t r;
        r.key = k; r.data = d; r.dec = dec;
        rq[i].push_back(r);
    endtask

    task automatic tick();
        int           g;
        logic [NREQ-1:0] oh;
        exp_t         e;
        @(negedge clk);
        cyc++;
        // core model
        core_out.ready  = 1'b0;
        core_out.result = rnd128();
        if (core_pend) begin
            core_lat--;
            if (core_lat == 0) begin
                core_out.ready  = 1'b1;
                core_out.result = core_res;
                core_pend       = 1'b0;
            end
        end
        if (core_in.enable && core_in.func == AES_FUNC_KEXP) begin
            exp_key = core_in.key;
            kexp_cnt++;
            kexp_cyc    = cyc;
            kexp_recent = 1'b1;
        end
        if (core_in.enable && (core_in.func == AES_FUNC_ENC || core_in.func == AES_FUNC_DEC)) begin
            start_cnt++;
            start_cyc = cyc;
            chk("start_key", core_in.key, exp_key);
            if (kexp_recent) chk("kwait_len", 256'(cyc - kexp_cyc), 256'(KEXP_CYC + 1));
            kexp_recent = 1'b0;
            core_res  = ref_core(exp_key, core_in.data, core_in.func == AES_FUNC_DEC);
            core_pend = !core_stuck;
            core_lat  = int'($urandom_range(1, 4));
        end
        // requester drive
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                rq[i].delete(0);
                acc[i] = 1'b0;
            end
            req_valid[i] = (rq[i].size() > 0);
            req_key[i*KEY_W +: KEY_W]    = req_valid[i] ? rq[i][0].key  : 256'd0;
            req_data[i*DATA_W +: DATA_W] = req_valid[i] ? rq[i][0].data : 128'd0;
            req_dec[i]                   = req_valid[i] ? rq[i][0].dec  : 1'b0;
        end
        rsp_ready = (rdy_mode == 2) || (rdy_mode == 0 && ($urandom % 10) < 7);
        #1;
        chk("busy", 256'(busy), 256'(expq.size() != 0));
        if (expq.size() != 0) begin
            chk("no_grant_busy", 256'(req_ready), 256'(0));
            if (rsp_valid) begin
                if (prev_vld && !prev_rdy) begin
                    chk("hold_idx", 256'(rsp_idx), 256'(prev_idx));
                    chk("hold_data", 256'(rsp_data), 256'(prev_data));
                end
                if (!prev_vld && tmo_mode) chk("tmo_len", 256'(cyc - start_cyc), 256'(TMO_CYC + 1));
                if (rsp_ready) begin
                    e = expq.pop_front();
                    chk("rsp_idx", 256'(rsp_idx), 256'(e.idx));
                    chk("rsp_data", 256'(rsp_data), 256'(e.data));
                    chk("rsp_err", 256'(rsp_err), 256'(e.err));
                    chk("kexp_pulses", 256'(kexp_cnt - kexp_base), 256'(e.kexp));
                    chk("start_pulses", 256'(start_cnt - start_base), 256'(1));
                    done_cnt++;
                end
            end
        end else begin
            chk("rsp_idle", 256'(rsp_valid), 256'(0));
            g  = model_pick(req_valid, mptr);
            oh = '0;
            if (g >= 0) oh[g] = 1'b1;
            chk("grant", 256'(req_ready), 256'(oh));
            if (g >= 0) begin
                e.idx  = g;
                e.kexp = (!mvld || mkey != rq[g][0].key) ? 1 : 0;
                e.err  = tmo_mode;
                e.data = tmo_mode ? 128'd0 : ref_core(rq[g][0].key, rq[g][0].data, rq[g][0].dec);
                mkey   = rq[g][0].key;
                mvld   = !tmo_mode;
                expq.push_back(e);
                gseq.push_back(g);
                acc[g]     = 1'b1;
                mptr       = (g + 1) % NREQ;
                kexp_base  = kexp_cnt;
                start_base = start_cnt;
            end
        end
        prev_vld  = rsp_valid;
        prev_rdy  = rsp_ready;
        prev_idx  = rsp_idx;
        prev_data = rsp_data;
    endtask

    task automatic run_until(input int target);
        int budget;
        budget = 3000;
        while (done_cnt < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("txn_done", 256'(done_cnt), 256'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] k, pool[3];
        int           base, target, pushed, budget;
        n_chk = 0; n_fail = 0; cyc = 0; done_cnt = 0; kexp_cnt = 0; start_cnt = 0;
        kexp_base = 0; start_base = 0; kexp_cyc = 0; start_cyc = 0; core_lat = 0; mptr = 0;
        mvld = 1'b0; core_pend = 1'b0; core_stuck = 1'b0; tmo_mode = 1'b0; kexp_recent = 1'b0;
        prev_vld = 1'b0; prev_rdy = 1'b0; prev_idx = '0; prev_data = '0; mkey = '0; exp_key = '0;
        core_res = '0; acc = '0; rdy_mode = 2;
        rst = 1'b1; req_valid = '0; req_dec = '0; req_key = '0; req_data = '0; rsp_ready = 1'b0;
        core_out = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("reset_req_ready", 256'(req_ready), 256'(0));
        chk("reset_rsp_data", 256'(rsp_data), 256'(0));
        chk("reset_rsp_idx", 256'(rsp_idx), 256'(0));
        chk("reset_rsp_err", 256'(rsp_err), 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_core_en", 256'(core_in.enable), 256'(0));
        chk("reset_core_key", core_in.key, 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 AES-256 encrypt, then decrypt from the other requester with the same key
        push(0, FIPS_KEY, FIPS_PT, 1'b0);
        run_until(1);
        push(1, FIPS_KEY, FIPS_CT, 1'b1);
        run_until(2);

        // both requesters busy with distinct keys: strict alternation, one expansion each
        gseq.delete();
        base = kexp_cnt;
        push(0, rnd256(), rnd128(), 1'b0);
        push(1, rnd256(), rnd128(), 1'b1);
        push(0, rnd256(), rnd128(), 1'b1);
        push(1, rnd256(), rnd128(), 1'b0);
        run_until(6);
        chk("alt_count", 256'(gseq.size()), 256'(4));
        for (int j = 0; j < gseq.size(); j++) chk("alt_grant", 256'(gseq[j]), 256'(j % 2));
        chk("alt_kexp", 256'(kexp_cnt - base), 256'(4));

        // response stall with a competing request pending
        rdy_mode = 1;
        push(0, rnd256(), rnd128(), 1'b0);
        push(1, rnd256(), rnd128(), 1'b0);
        budget = 200;
        while (!rsp_valid && budget > 0) begin
            tick();
            budget--;
        end
        chk("stall_rsp_seen", 256'(rsp_valid), 256'(1));
        repeat (10) tick();
        rdy_mode = 2;
        run_until(8);

        // randomized traffic over a small key pool so reuse and changes both occur
        rdy_mode = 0;
        for (int j = 0; j < 3; j++) pool[j] = rnd256();
        target = done_cnt + 30;
        pushed = 0;
        budget = 5000;
        while ((pushed < 30 || done_cnt < target) && budget > 0) begin
            if (pushed < 30 && $urandom_range(0, 5) == 0) begin
                push(int'($urandom_range(0, NREQ - 1)), pool[$urandom_range(0, 2)], rnd128(), 1'($urandom));
                pushed++;
            end
            tick();
            budget--;
        end
        chk("rand_done", 256'(done_cnt), 256'(target));

        // reset while waiting on the core
        rdy_mode = 2;
        core_stuck = 1'b1;
        k = rnd256();
        push(0, k, rnd128(), 1'b0);
        base = start_cnt;
        budget = 100;
        while (start_cnt == base && budget > 0) begin
            tick();
            budget--;
        end
        chk("rst_reached_start", 256'(start_cnt - base), 256'(1));
        tick();
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_rsp_data", 256'(rsp_data), 256'(0));
        chk("rst_rsp_idx", 256'(rsp_idx), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_core_en", 256'(core_in.enable), 256'(0));
        chk("rst_core_data", 256'(core_in.data), 256'(0));
        expq.delete();
        mvld = 1'b0; mptr = 0; core_pend = 1'b0; kexp_recent = 1'b0; prev_vld = 1'b0;
        core_stuck = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = kexp_cnt;
        push(0, k, rnd128(), 1'b0);
        run_until(done_cnt + 1);
        chk("rst_rekexp", 256'(kexp_cnt - base), 256'(1));

`ifdef AES_SCHED_TMO_EN
        // hung core: watchdog answers with an error and forces re-expansion
        core_stuck = 1'b1;
        tmo_mode = 1'b1;
        k = rnd256();
        push(1, k, rnd128(), 1'b1);
        run_until(done_cnt + 1);
        tmo_mode = 1'b0;
        core_stuck = 1'b0;
        base = kexp_cnt;
        push(1, k, rnd128(), 1'b0);
        run_until(done_cnt + 1);
        chk("tmo_rekexp", 256'(kexp_cnt - base), 256'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
